// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the loader.
// The slave modport is the loader side; the master modport is the stream source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, err
    );

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a header + big-endian byte stream while holding the CPU.
// Define IMEM_LOADER_CKSUM_EN to add a trailing XOR checksum byte that drives err on mismatch.
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);
`ifdef IMEM_LOADER_CKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, ASM, WR, CK, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, ASM, WR, FIN} state_t;
`endif

    state_t            r_state;
    logic              r_byte_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_waddr;
    logic [31:0]       r_mem_wdata;
    logic              r_cpu_hold;
    logic              r_done;
    logic [1:0]        r_bcnt;
    logic [ADDR_W-1:0] r_wcnt;
    logic [ADDR_W-1:0] r_last;
    logic [23:0]       r_shift;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]        r_xor;
    logic              r_err;
`endif

    logic              w_xfer;
    logic [5:0]        w_len;
    logic [ADDR_W-1:0] w_last;
    logic [31:0]       w_word;

    assign w_xfer = bus.byte_valid && r_byte_ready;
    assign w_len  = bus.byte_data[5:0];
    // A header of 0 or anything past the memory size means "fill the whole memory".
    assign w_last = (w_len == 6'd0 || int'(w_len) > DEPTH) ? ADDR_W'(DEPTH - 1) : ADDR_W'(w_len - 6'd1);
    assign w_word = {r_shift, bus.byte_data};

    assign bus.byte_ready = r_byte_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_waddr  = r_mem_waddr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.cpu_hold   = r_cpu_hold;
    assign bus.done       = r_done;
`ifdef IMEM_LOADER_CKSUM_EN
    assign bus.err        = r_err;
`else
    assign bus.err        = 1'b0;
`endif

    // Load sequencer: header, 4-byte word assembly, one-cycle write, optional checksum, finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_waddr  <= '0;
            r_mem_wdata  <= '0;
            r_cpu_hold   <= 1'b0;
            r_done       <= 1'b0;
            r_bcnt       <= '0;
            r_wcnt       <= '0;
            r_last       <= '0;
            r_shift      <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            r_xor        <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state      <= HDR;
                        r_byte_ready <= 1'b1;
                        r_cpu_hold   <= 1'b1;
                        r_done       <= 1'b0;
                        r_bcnt       <= '0;
                        r_wcnt       <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
                        r_xor        <= '0;
                        r_err        <= 1'b0;
`endif
                    end
                end
                HDR: begin
                    if (w_xfer) begin
                        r_last  <= w_last;
                        r_state <= ASM;
                    end
                end
                ASM: begin
                    if (w_xfer) begin
                        r_shift <= w_word[23:0];
                        r_bcnt  <= r_bcnt + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                        r_xor   <= r_xor ^ bus.byte_data;
`endif
                        if (r_bcnt == 2'd3) begin
                            r_state      <= WR;
                            r_byte_ready <= 1'b0;
                            r_mem_we     <= 1'b1;
                            r_mem_waddr  <= r_wcnt;
                            r_mem_wdata  <= w_word;
                        end
                    end
                end
                WR: begin
                    r_wcnt <= r_wcnt + ADDR_W'(1);
                    if (r_wcnt == r_last) begin
`ifdef IMEM_LOADER_CKSUM_EN
                        r_state      <= CK;
                        r_byte_ready <= 1'b1;
`else
                        r_state      <= FIN;
                        r_cpu_hold   <= 1'b0;
                        r_done       <= 1'b1;
`endif
                    end else begin
                        r_state      <= ASM;
                        r_byte_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CKSUM_EN
                CK: begin
                    if (w_xfer) begin
                        r_err        <= bus.byte_data != r_xor;
                        r_byte_ready <= 1'b0;
                        r_cpu_hold   <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= FIN;
                    end
                end
`endif
                FIN: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed + randomized loads checked against a word-packing model of the stream.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst_n;
    int tests = 0;
    int fails = 0;
    int cyc = 0, acc = 0, last_acc = 0, last_wr = 0, rdy_in_wr = 0;
    int data_acc = 0;
    int a0, w0;
    logic [4:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  stim[$];

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(5)) bus ();
    imem_loader #(.ADDR_W(5), .DEPTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Observe transfers and memory writes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.byte_valid && bus.byte_ready) begin
            acc      <= acc + 1;
            last_acc <= cyc;
        end
        if (bus.mem_we) begin
            wa_q.push_back(bus.mem_waddr);
            wd_q.push_back(bus.mem_wdata);
            last_wr <= cyc;
            if (bus.byte_ready) rdy_in_wr <= rdy_in_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int n_of(input logic [7:0] h);
        int v;
        v = int'(h[5:0]);
        return (v == 0 || v > 32) ? 32 : v;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.byte_ready), 0);
        chk({tag, "_we"}, 32'(bus.mem_we), 0);
        chk({tag, "_waddr"}, 32'(bus.mem_waddr), 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_hold"}, 32'(bus.cpu_hold), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_err"}, 32'(bus.err), 0);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus.byte_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        chk("byte_accept", 32'(ok), 1);
    endtask

    // gap: 0 back-to-back, 1 valid toggling every cycle, 2 random idle cycles.
    task automatic run_load(input logic [7:0] hdr, input int gap, input logic [7:0] ck_flip, input bit mid_start);
        int n, w_base, a_base, g, ck;
        logic [7:0] x;
        logic [31:0] word;
        n = n_of(hdr);
        w_base = wa_q.size();
        a_base = acc;
        x = 8'h00;
        ck = 0;
        pulse_start();
        chk("start_done_clr", 32'(bus.done), 0);
        chk("start_hold", 32'(bus.cpu_hold), 1);
        chk("start_err_clr", 32'(bus.err), 0);
        send(hdr);
        for (int i = 0; i < n * 4; i++) begin
            g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 3)) : 0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            send(stim[i]);
            x ^= stim[i];
            if (mid_start && i == 1) begin
                pulse_start();
                chk("mid_start_ready", 32'(bus.byte_ready), 1);
                chk("mid_start_hold", 32'(bus.cpu_hold), 1);
                chk("mid_start_done", 32'(bus.done), 0);
            end
        end
        data_acc = last_acc;
`ifdef IMEM_LOADER_CKSUM_EN
        send(x ^ ck_flip);
        ck = 1;
`endif
        for (int k = 0; k < 20 && !bus.done; k++) @(negedge clk);
        chk("done", 32'(bus.done), 1);
        chk("hold_low", 32'(bus.cpu_hold), 0);
        chk("err", 32'(bus.err), 32'(ck == 1 && ck_flip != 8'h00));
        chk("write_count", 32'(wa_q.size() - w_base), 32'(n));
        for (int i = 0; i < n && w_base + i < wa_q.size(); i++) begin
            word = {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
            chk("waddr", 32'(wa_q[w_base+i]), 32'(i));
            chk("wdata", wd_q[w_base+i], word);
        end
        chk("wr_latency", 32'(last_wr - data_acc), 1);
        chk("bytes_accepted", 32'(acc - a_base), 32'(n * 4 + 1 + ck));
        chk("ready_in_wr", 32'(rdy_in_wr), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", 32'(bus.done), 1);
        chk("hold_held_low", 32'(bus.cpu_hold), 0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        rst_n          = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        stim = '{8'h20, 8'h08, 8'h00, 8'h00, 8'h20, 8'h09, 8'h00, 8'h01};
        run_load(8'h02, 0, 8'h00, 1'b0);
        chk("t1_word0", wd_q[wd_q.size()-2], 32'h20080000);
        chk("t1_word1", wd_q[wd_q.size()-1], 32'h20090001);

        stim.delete();
        for (int i = 0; i < 128; i++) stim.push_back(8'(i));
        run_load(8'h00, 0, 8'h00, 1'b0);
        chk("t2_last_addr", 32'(wa_q[wa_q.size()-1]), 31);
        chk("t2_last_data", wd_q[wd_q.size()-1], 32'h7C7D7E7F);

        stim = '{8'h01, 8'h09, 8'h40, 8'h20};
        run_load(8'h01, 1, 8'h00, 1'b0);
        chk("t3_word", wd_q[wd_q.size()-1], 32'h01094020);

        a0 = acc;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hA5;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_no_consume", 32'(acc - a0), 0);
        chk("idle_ready", 32'(bus.byte_ready), 0);
        chk("idle_done_held", 32'(bus.done), 1);
        bus.byte_valid = 1'b0;

        stim.delete();
        repeat (8) stim.push_back(8'($urandom));
        run_load(8'h02, 0, 8'h00, 1'b1);

        w0 = wa_q.size();
        stim.delete();
        repeat (12) stim.push_back(8'($urandom));
        pulse_start();
        send(8'h03);
        for (int i = 0; i < 6; i++) send(stim[i]);
        rst_n = 1'b0;
        #1;
        chk_zero("midload_reset");
        chk("midload_writes", 32'(wa_q.size() - w0), 1);
        chk("midload_addr0", 32'(wa_q[w0]), 0);
        chk("midload_data0", wd_q[w0], {stim[0], stim[1], stim[2], stim[3]});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_load(8'h03, 2, 8'h00, 1'b0);

        for (int r = 0; r < 4; r++) begin
            logic [7:0] h;
            h = 8'($urandom);
            stim.delete();
            repeat (n_of(h) * 4) stim.push_back(8'($urandom));
            run_load(h, 2, 8'h00, 1'b0);
        end

`ifdef IMEM_LOADER_CKSUM_EN
        stim = '{8'h21, 8'h29, 8'h00, 8'h01};
        run_load(8'h01, 0, 8'h00, 1'b0);
        run_load(8'h01, 0, 8'h01, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
